// File: rtl/handshake_pkg.sv
// Definitions shared between the handshake patting pipes and the FIFO stage
// that buffers their output.
package handshake_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_W register array with one write port and an asynchronous read
// port, so the FIFO head is visible in the same cycle its address is.
module handshake_fifo_mem #(
   parameter int DATA_W = handshake_pkg::DATA_W,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   // No reset on the storage: contents are only observable behind slave_valid.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo_stage.sv
// First-word fall-through valid/ready FIFO that absorbs bursts downstream of
// the patting pipes. master_ready and almost_full are registered.
module handshake_fifo_stage #(
   parameter int DATA_W   = handshake_pkg::DATA_W,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   master_valid,
   input  logic [DATA_W-1:0]      master_data,
   output logic                   master_ready,
   output logic                   slave_valid,
   output logic [DATA_W-1:0]      slave_data,
   input  logic                   slave_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_next;
   logic          push;
   logic          pop;

   assign slave_valid = (count != '0);
   assign push        = master_valid & master_ready;
   assign pop         = slave_valid & slave_ready;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Flags come from count_next so they line up with count, while keeping
   // slave_ready off any combinational path to master_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         master_ready <= 1'b0;
         almost_full  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count        <= count_next;
         master_ready <= (count_next != FULL_CNT);
         almost_full  <= (count_next >= AF_CNT);
      end
   end

   handshake_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (master_data),
      .raddr (rd_ptr),
      .rdata (slave_data)
   );

endmodule
